// File: rtl/layer_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : layer_step_ctrl
// Purpose  : Turns level-sensitive next/prev buttons into single layer steps
//            over NUM_LAYERS layers (wrap or saturate), with a direct-load
//            port. Hold-to-repeat is built when LAYER_STEP_REPEAT_EN is
//            defined; otherwise every press gives exactly one step.
// Revision : 1.0 - initial release
// ============================================================================
module layer_step_ctrl #(
   parameter int NUM_LAYERS    = 8,
   parameter int WRAP          = 1,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   localparam int LW           = $clog2(NUM_LAYERS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          next,
   input  logic          prev,
   input  logic          load,
   input  logic [LW-1:0] load_layer,
   output logic [LW-1:0] layer,
   output logic          changed
);

   // Highest legal layer, one bit wider so non-power-of-2 counts compare cleanly
   localparam logic [LW:0] LAST = (LW+1)'(NUM_LAYERS - 1);

   logic          next_q, prev_q;
   logic          lockout, lockout_nxt;
   logic [LW-1:0] layer_nxt;
   logic [LW-1:0] up_val, dn_val;
   logic          rise_next, rise_prev;
   logic          load_ok;

   assign rise_next = next & ~next_q;
   assign rise_prev = prev & ~prev_q;
   assign load_ok   = ({1'b0, load_layer} <= LAST);

`ifdef LAYER_STEP_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(RMAX + 1);
   localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          dir_up, dir_up_nxt;
   logic          held, other;

   assign held  = dir_up ? next : prev;
   assign other = dir_up ? prev : next;
`else
   // Repeat timing is not built in this configuration; keep the knobs referenced
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

   // Candidate values for one step up / down, honouring wrap or saturate
   always_comb begin
      up_val = layer;
      dn_val = layer;
      if ({1'b0, layer} >= LAST) begin
         if (WRAP != 0) up_val = '0;
      end else begin
         up_val = layer + 1'b1;
      end
      if (layer == '0) begin
         if (WRAP != 0) dn_val = LAST[LW-1:0];
      end else begin
         dn_val = layer - 1'b1;
      end
   end

   // Priority decode: load, both-pressed, single rise, then repeat tick
   always_comb begin
      layer_nxt   = layer;
      lockout_nxt = lockout;
`ifdef LAYER_STEP_REPEAT_EN
      state_nxt   = state;
      cnt_nxt     = cnt;
      dir_up_nxt  = dir_up;
`endif
      if (!next && !prev) lockout_nxt = 1'b0;

      if (load) begin
         if (load_ok) layer_nxt = load_layer;
         lockout_nxt = 1'b1;
`ifdef LAYER_STEP_REPEAT_EN
         state_nxt   = IDLE;
         cnt_nxt     = '0;
`endif
      end else if (next && prev) begin
         // Ambiguous request: no step, abandon any hold in progress
`ifdef LAYER_STEP_REPEAT_EN
         state_nxt = IDLE;
         cnt_nxt   = '0;
`endif
      end else if (!lockout && (rise_next ^ rise_prev)) begin
         layer_nxt = rise_next ? up_val : dn_val;
`ifdef LAYER_STEP_REPEAT_EN
         state_nxt  = DELAY;
         cnt_nxt    = '0;
         dir_up_nxt = rise_next;
`endif
      end
`ifdef LAYER_STEP_REPEAT_EN
      else if (state != IDLE) begin
         if (!held || other || lockout) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else if (cnt == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
            layer_nxt = dir_up ? up_val : dn_val;
            state_nxt = REPEAT;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
`endif
   end

   // Layer, change pulse, edge history and lockout registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         layer   <= '0;
         changed <= 1'b0;
         next_q  <= 1'b1;
         prev_q  <= 1'b1;
         lockout <= 1'b0;
      end else begin
         layer   <= layer_nxt;
         changed <= (layer_nxt != layer);
         next_q  <= next;
         prev_q  <= prev;
         lockout <= lockout_nxt;
      end
   end

`ifdef LAYER_STEP_REPEAT_EN
   // Hold-to-repeat state, counter and held direction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         dir_up <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         dir_up <= dir_up_nxt;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_step_ctrl
// Purpose  : Directed self-checking bench for layer_step_ctrl (5 layers,
//            wrap instance plus a saturating instance). Expectations follow
//            LAYER_STEP_REPEAT_EN as seen by this file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_step_ctrl;

`ifdef LAYER_STEP_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       next, prev, load;
   logic [2:0] load_layer;
   logic [2:0] layer;
   logic       changed;
   logic       s_next, s_prev, s_load;
   logic [2:0] s_load_layer;
   logic [2:0] s_layer;
   logic       s_changed;

   int n_checks = 0;
   int n_err    = 0;
   int hold_exp [8] = '{1, 1, 1, 2, 2, 3, 3, 4};

   always #5 clk = ~clk;

   layer_step_ctrl #(.NUM_LAYERS(5), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
      .clk(clk), .reset(reset), .next(next), .prev(prev), .load(load),
      .load_layer(load_layer), .layer(layer), .changed(changed)
   );

   layer_step_ctrl #(.NUM_LAYERS(5), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_s (
      .clk(clk), .reset(reset), .next(s_next), .prev(s_prev), .load(s_load),
      .load_layer(s_load_layer), .layer(s_layer), .changed(s_changed)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_next(input int exp, input string tag);
      next = 1'b1;
      tick();
      check(tag, 32'(layer), 32'(exp));
      next = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; next = 1'b1; prev = 1'b0; load = 1'b0; load_layer = '0;
      s_next = 1'b0; s_prev = 1'b0; s_load = 1'b0; s_load_layer = '0;
      tick(); tick();
      check("reset_layer", 32'(layer), 32'd0);
      check("reset_changed", 32'(changed), 32'd0);
      reset = 1'b0;
      // next held through reset release must not step
      for (int i = 0; i < 3; i++) begin
         tick();
         check("held_thru_reset_layer", 32'(layer), 32'd0);
         check("held_thru_reset_changed", 32'(changed), 32'd0);
      end
      next = 1'b0; tick();
      next = 1'b1; tick();
      check("first_step_layer", 32'(layer), 32'd1);
      check("first_step_changed", 32'(changed), 32'd1);
      next = 1'b0; tick();
      check("changed_one_cycle", 32'(changed), 32'd0);

      // back to layer 0
      load = 1'b1; load_layer = 3'd0; tick();
      check("load0_layer", 32'(layer), 32'd0);
      check("load0_changed", 32'(changed), 32'd1);
      load = 1'b0; tick(); tick();

      // five next pulses wrap through all layers
      pulse_next(1, "pulse1");
      pulse_next(2, "pulse2");
      pulse_next(3, "pulse3");
      pulse_next(4, "pulse4");
      pulse_next(0, "pulse_wrap");
      prev = 1'b1; tick();
      check("prev_wrap", 32'(layer), 32'd4);
      prev = 1'b0; tick();
      pulse_next(0, "next_wrap_again");

      // hold next: steps at E0, E0+4, E0+6, E0+8
      next = 1'b1; tick();
      check("hold_E0", 32'(layer), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("hold_step", 32'(layer), REP ? 32'(hold_exp[i-1]) : 32'd1);
         if (i == 4) check("hold_changed_E4", 32'(changed), REP ? 32'd1 : 32'd0);
         if (i == 5) check("hold_changed_E5", 32'(changed), 32'd0);
      end

      // load while repeating, then lockout until release
      load = 1'b1; load_layer = 3'd3; tick();
      check("load_in_repeat", 32'(layer), 32'd3);
      check("load_in_repeat_changed", 32'(changed), 32'd1);
      load = 1'b0;
      repeat (10) tick();
      check("lockout_layer", 32'(layer), 32'd3);
      check("lockout_changed", 32'(changed), 32'd0);
      next = 1'b0; tick();
      pulse_next(4, "after_lockout");

      // out-of-range load ignored
      load = 1'b1; load_layer = 3'd6; tick();
      check("bad_load_layer", 32'(layer), 32'd4);
      check("bad_load_changed", 32'(changed), 32'd0);
      load = 1'b0; tick(); tick();

      // simultaneous rises
      next = 1'b1; prev = 1'b1; tick();
      check("both_rise_layer", 32'(layer), 32'd4);
      check("both_rise_changed", 32'(changed), 32'd0);
      next = 1'b0; prev = 1'b0; tick();

      // prev pressed while next held in DELAY cancels the hold
      next = 1'b1; tick();
      check("delay_start", 32'(layer), 32'd0);
      tick(); tick();
      prev = 1'b1; tick();
      check("other_pressed", 32'(layer), 32'd0);
      prev = 1'b0;
      repeat (6) tick();
      check("idle_after_cancel", 32'(layer), 32'd0);
      next = 1'b0; tick();

      // release one cycle and re-press restarts the delay
      next = 1'b1; tick();
      check("repress_a", 32'(layer), 32'd1);
      tick(); tick();
      next = 1'b0; tick();
      next = 1'b1; tick();
      check("repress_b", 32'(layer), 32'd2);
      tick(); tick(); tick();
      check("delay_restarted", 32'(layer), 32'd2);
      next = 1'b0; tick();

      // asynchronous reset mid-hold
      next = 1'b1; tick();
      check("pre_reset_step", 32'(layer), 32'd3);
      tick();
      #2 reset = 1'b1;
      #1 check("async_reset_layer", 32'(layer), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) tick();
      check("held_after_reset", 32'(layer), 32'd0);
      next = 1'b0; tick();
      pulse_next(1, "step_after_reset");

      // saturating instance
      s_prev = 1'b1; tick();
      check("sat_prev_at0", 32'(s_layer), 32'd0);
      check("sat_prev_changed", 32'(s_changed), 32'd0);
      s_prev = 1'b0; tick();
      s_load = 1'b1; s_load_layer = 3'd4; tick();
      check("sat_load4", 32'(s_layer), 32'd4);
      s_load = 1'b0; tick(); tick();
      s_next = 1'b1; tick();
      check("sat_next_at4", 32'(s_layer), 32'd4);
      check("sat_next_changed", 32'(s_changed), 32'd0);
      s_next = 1'b0; tick();
      s_prev = 1'b1; tick();
      check("sat_prev_from4", 32'(s_layer), 32'd3);
      s_prev = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
